// File: rtl/alu.sv
// alu: signed ALU with sum/diff/xor/and plus a bit-serial signed multiplier.
// Optional busy output under macro ALU_BUSY_EN.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] diff,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   xor_out,
  output logic [WIDTH-1:0]   and_out,
`ifdef ALU_BUSY_EN
  output logic               busy,
`endif
  output logic               done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mcand, mplr;
  logic [2*WIDTH-1:0] acc, acc_nxt, term, ext_a, ext_b;
  logic [CW-1:0] cnt;
  logic last;
  always_comb begin
    ext_a = {{WIDTH{A[WIDTH-1]}}, A};
    ext_b = {{WIDTH{B[WIDTH-1]}}, B};
    last = cnt == CW'(WIDTH-1);
    term = {{WIDTH{mcand[WIDTH-1]}}, mcand} << cnt;
    // the top multiplier bit carries negative weight
    acc_nxt = !mplr[0] ? acc : last ? acc - term : acc + term;
    state_nxt = state;
    if (state == IDLE && start) state_nxt = BUSY;
    if (state == BUSY && last) state_nxt = IDLE;
  end
`ifdef ALU_BUSY_EN
  assign busy = state == BUSY;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      sum     <= '0;
      diff    <= '0;
      prod    <= '0;
      xor_out <= '0;
      and_out <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        mcand   <= A;
        mplr    <= B;
        acc     <= '0;
        cnt     <= '0;
        sum     <= ext_a + ext_b;
        diff    <= ext_a - ext_b;
        xor_out <= A ^ B;
        and_out <= A & B;
      end else if (state == BUSY) begin
        acc  <= acc_nxt;
        mplr <= mplr >> 1;
        cnt  <= cnt + 1'b1;
        if (last) begin
          prod <= acc_nxt;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random checks of alu against an integer-arithmetic model.
module tb_alu;
  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] A, B, xor_out, and_out;
  logic [15:0] sum, diff, prod;
  logic done;
`ifdef ALU_BUSY_EN
  logic busy;
`endif
  int n = 0;
  int miss = 0;
  alu dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .sum(sum), .diff(diff), .prod(prod), .xor_out(xor_out), .and_out(and_out),
`ifdef ALU_BUSY_EN
    .busy(busy),
`endif
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cap(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    @(posedge clk); #1;
    chk("sum", sum, 16'(ia + ib));
    chk("diff", diff, 16'(ia - ib));
    chk("xor", {8'h0, xor_out}, {8'h0, a ^ b});
    chk("and", {8'h0, and_out}, {8'h0, a & b});
    chk("done_early", {15'h0, done}, 16'h0);
`ifdef ALU_BUSY_EN
    chk("busy_on", {15'h0, busy}, 16'h1);
`endif
  endtask
  task automatic fin(input logic [7:0] a, input logic [7:0] b, input int lat);
    int ia, ib, k;
    ia = $signed(a);
    ib = $signed(b);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!done && k < 12);
    chk("latency", 16'(k), 16'(lat));
    chk("prod", prod, 16'(ia * ib));
  endtask
  task automatic settle();
    @(posedge clk); #1;
    chk("done_single", {15'h0, done}, 16'h0);
`ifdef ALU_BUSY_EN
    chk("busy_off", {15'h0, busy}, 16'h0);
`endif
  endtask
  initial begin
    logic [7:0] ca, cb;
    int hits;
    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, 16'h0);
    chk("rst_prod", prod, 16'h0);
    chk("rst_logic", {xor_out, and_out}, 16'h0);
    chk("rst_done", {15'h0, done}, 16'h0);
    rst = 1'b1;
    // spec vector, start held for two cycles
    A = 8'hE9; B = 8'h31; start = 1'b1;
    cap(A, B);
    @(posedge clk); #1; start = 1'b0;
    fin(8'hE9, 8'h31, 7);
    chk("t1_prod", prod, 16'hFB99);
    chk("t1_sum", sum, 16'h001A);
    chk("t1_diff", diff, 16'hFFB8);
    settle();
    // boundary operands
    for (int i = 0; i < 3; i++) begin
      ca = i == 2 ? 8'h7F : i == 1 ? 8'h7F : 8'h80;
      cb = i == 2 ? 8'h7F : 8'h80;
      A = ca; B = cb; start = 1'b1;
      cap(ca, cb);
      start = 1'b0;
      fin(ca, cb, 8);
      settle();
    end
    chk("7f7f_prod", prod, 16'h3F01);
    chk("7f7f_sum", sum, 16'h00FE);
    // operand changes and start pulse during BUSY must be ignored
    ca = 8'h9C; cb = 8'h5B;
    A = ca; B = cb; start = 1'b1;
    cap(ca, cb);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1; A = 8'h11; B = 8'hF3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    fin(ca, cb, 5);
    chk("busy_sum_hold", sum, 16'(int'($signed(ca)) + int'($signed(cb))));
    settle();
    // async reset at E4 aborts the operation
    A = 8'h45; B = 8'hC7; start = 1'b1;
    cap(A, B);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst = 1'b0; #1;
    chk("abort_sum", sum, 16'h0);
    chk("abort_diff", diff, 16'h0);
    chk("abort_prod", prod, 16'h0);
    chk("abort_logic", {xor_out, and_out}, 16'h0);
    @(negedge clk); rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; hits += int'(done); end
    chk("abort_nodone", 16'(hits), 16'h0);
    ca = 8'hD3; cb = 8'h0E;
    A = ca; B = cb; start = 1'b1;
    cap(ca, cb);
    start = 1'b0;
    fin(ca, cb, 8);
    settle();
    // random single operations
    for (int i = 0; i < 20; i++) begin
      ca = 8'($urandom); cb = 8'($urandom);
      A = ca; B = cb; start = 1'b1;
      cap(ca, cb);
      start = 1'b0;
      fin(ca, cb, 8);
      settle();
    end
    // start held high: back-to-back operations every 9 clocks
    A = 8'($urandom); B = 8'($urandom); start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ca = A; cb = B;
      cap(ca, cb);
      A = 8'($urandom); B = 8'($urandom);
      fin(ca, cb, 8);
    end
    start = 1'b0;
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n, miss);
    $finish;
  end
endmodule
